// File: rtl/game_over_ctrl_if.sv
// game_over_ctrl_if: pixel stream, sprite ROM and colour output bus around the game-over overlay.
interface game_over_ctrl_if;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] game_rgb;
  logic [11:0] rom_color;
  logic [4:0]  rom_row;
  logic [5:0]  rom_col;
  logic [11:0] rgb_out;
  modport master (
    output video_on, pixel_x, pixel_y, game_rgb, rom_color,
    input  rom_row, rom_col, rgb_out
  );
  modport slave (
    input  video_on, pixel_x, pixel_y, game_rgb, rom_color,
    output rom_row, rom_col, rgb_out
  );
endinterface

// File: rtl/game_over_ctrl.sv
// game_over_ctrl: game-over sprite overlay pipeline and freeze/flash/show/restart sequencer.
module game_over_ctrl #(
  parameter int SHIFT         = 3,
  parameter int X_OFFSET      = 64,
  parameter int Y_OFFSET      = 112,
  parameter int FLASH_FRAMES  = 15,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic game_over,
  input  logic restart_btn,
  game_over_ctrl_if.slave vid,
  output logic freeze,
  output logic restart_req
);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [9:0] X_LO = 10'(X_OFFSET);
  localparam logic [9:0] Y_LO = 10'(Y_OFFSET);
  localparam logic [9:0] X_HI = 10'(X_OFFSET + (64 << SHIFT));
  localparam logic [9:0] Y_HI = 10'(Y_OFFSET + (32 << SHIFT));

  typedef enum logic [1:0] {PLAY, FLASH, SHOW, RESTART} state_t;

  state_t          state, state_n;
  logic [FW-1:0]   frame_cnt;
  logic [TW-1:0]   toggle_cnt;
  logic            vis, pend, wrap, last, go;
  logic [9:0]      dx, dy;
  logic            in_win;
  logic [1:0]      win_d, von_d;
  logic [11:0]     rgb_d1, rgb_d2, dim_rgb, out_rgb;

  assign dx     = vid.pixel_x - X_LO;
  assign dy     = vid.pixel_y - Y_LO;
  assign in_win = vid.pixel_x >= X_LO && vid.pixel_x < X_HI && vid.pixel_y >= Y_LO && vid.pixel_y < Y_HI;

  // ROM adds one cycle after the address register, so side-band signals ride two stages
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vid.rom_row <= '0;
      vid.rom_col <= '0;
      win_d       <= '0;
      von_d       <= '0;
      rgb_d1      <= '0;
      rgb_d2      <= '0;
      vid.rgb_out <= '0;
    end else begin
      vid.rom_row <= in_win ? 5'(dy >> SHIFT) : '0;
      vid.rom_col <= in_win ? 6'(dx >> SHIFT) : '0;
      win_d       <= {win_d[0], in_win};
      von_d       <= {von_d[0], vid.video_on};
      rgb_d1      <= vid.game_rgb;
      rgb_d2      <= rgb_d1;
      vid.rgb_out <= out_rgb;
    end

  assign dim_rgb = {1'b0, rgb_d2[11:9], 1'b0, rgb_d2[7:5], 1'b0, rgb_d2[3:1]};

  // outside PLAY everything not covered by a visible sprite pixel is dimmed
  always_comb
    out_rgb = !von_d[1] ? 12'h000 :
              state == PLAY ? rgb_d2 :
              (vis && win_d[1] && vid.rom_color != 12'h000) ? vid.rom_color : dim_rgb;

  assign wrap = frame_cnt == FW'(FLASH_FRAMES - 1);
  assign last = wrap && toggle_cnt == TW'(FLASH_TOGGLES - 1);
  assign go   = pend || restart_btn;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= PLAY;
      frame_cnt   <= '0;
      toggle_cnt  <= '0;
      vis         <= 1'b0;
      pend        <= 1'b0;
      restart_req <= 1'b0;
    end else begin
      state       <= state_n;
      restart_req <= state == SHOW && state_n == RESTART;
      pend        <= state == SHOW && state_n == SHOW && go;
      if (frame_tick) begin
        if (state == PLAY && state_n == FLASH) begin
          vis        <= 1'b1;
          frame_cnt  <= '0;
          toggle_cnt <= '0;
        end else if (state == FLASH) begin
          frame_cnt <= wrap ? '0 : frame_cnt + FW'(1);
          if (wrap) begin
            vis        <= last || !vis;
            toggle_cnt <= toggle_cnt + TW'(1);
          end
        end else if (state == RESTART && state_n == PLAY)
          vis <= 1'b0;
      end
    end

  always_comb begin
    state_n = state;
    if (frame_tick)
      case (state)
        PLAY:    state_n = game_over ? FLASH : PLAY;
        FLASH:   state_n = last ? SHOW : FLASH;
        SHOW:    state_n = go ? RESTART : SHOW;
        default: state_n = game_over ? RESTART : PLAY;
      endcase
  end

  always_comb freeze = state != PLAY;
endmodule

// File: tb/tb_game_over_ctrl.sv
// tb_game_over_ctrl: directed checks of overlay pipeline, flash timing and restart handshake.
module tb_game_over_ctrl;
  logic clk = 1'b0;
  logic reset, frame_tick, game_over, restart_btn, freeze, restart_req;
  int checks = 0;
  int errors = 0;

  game_over_ctrl_if vid();

  game_over_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
    .restart_btn(restart_btn), .vid(vid), .freeze(freeze), .restart_req(restart_req)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(logic [4:0] r, logic [5:0] c);
    return (c == 6'd63) ? 12'h000 : {r, c, 1'b1};
  endfunction

  always @(posedge clk) vid.rom_color <= rom_f(vid.rom_row, vid.rom_col);

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic pix(int x, int y);
    vid.pixel_x = 10'(x);
    vid.pixel_y = 10'(y);
  endtask

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; game_over = 1'b0; restart_btn = 1'b0;
    vid.video_on = 1'b1; vid.game_rgb = 12'hF84; pix(0, 0);
    step(2);
    chk("rst_rgb", vid.rgb_out, 12'h000);
    chk("rst_freeze", 12'(freeze), 12'h0);
    chk("rst_row", 12'(vid.rom_row), 12'h0);
    chk("rst_req", 12'(restart_req), 12'h0);
    reset = 1'b0;
    step(3);
    chk("play_rgb", vid.rgb_out, 12'hF84);
    vid.game_rgb = 12'h123;
    step(2);
    chk("lat_early", vid.rgb_out, 12'hF84);
    step(1);
    chk("lat_exact", vid.rgb_out, 12'h123);
    vid.game_rgb = 12'hF84;
    game_over = 1'b1;
    step(3);
    chk("freeze_wait", 12'(freeze), 12'h0);
    tick();
    chk("freeze_on", 12'(freeze), 12'h1);
    pix(64, 112);
    step(1);
    chk("row_org", 12'(vid.rom_row), 12'h0);
    chk("col_org", 12'(vid.rom_col), 12'h0);
    step(2);
    chk("rgb_org", vid.rgb_out, 12'h001);
    pix(327, 175);
    step(1);
    chk("row_mid", 12'(vid.rom_row), 12'h7);
    chk("col_mid", 12'(vid.rom_col), 12'h20);
    step(1);
    chk("rgb_mid_early", vid.rgb_out, 12'h001);
    step(1);
    chk("rgb_mid", vid.rgb_out, 12'h3C1);
    pix(576, 112);
    step(1);
    chk("row_out", 12'(vid.rom_row), 12'h0);
    chk("col_out", 12'(vid.rom_col), 12'h0);
    step(2);
    chk("rgb_out_dim", vid.rgb_out, 12'h742);
    pix(568, 112);
    step(1);
    chk("col_edge", 12'(vid.rom_col), 12'h3F);
    step(2);
    chk("rgb_blank_cell", vid.rgb_out, 12'h742);
    pix(327, 175);
    vid.video_on = 1'b0;
    step(3);
    chk("blank_video", vid.rgb_out, 12'h000);
    vid.video_on = 1'b1;
    restart_btn = 1'b1;
    step(1);
    restart_btn = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      if (i == 50) begin
        restart_btn = 1'b1;
        step(1);
        restart_btn = 1'b0;
      end
      tick();
      chk($sformatf("flash_req_%0d", i), 12'(restart_req), 12'h0);
      step(3);
      chk($sformatf("flash_vis_%0d", i), vid.rgb_out, ((i / 15) % 2 == 0) ? 12'h3C1 : 12'h742);
    end
    tick();
    chk("show_no_latch", 12'(restart_req), 12'h0);
    chk("show_freeze", 12'(freeze), 12'h1);
    restart_btn = 1'b1;
    step(1);
    restart_btn = 1'b0;
    step(2);
    chk("req_wait", 12'(restart_req), 12'h0);
    tick();
    chk("req_pulse", 12'(restart_req), 12'h1);
    step(1);
    chk("req_single", 12'(restart_req), 12'h0);
    tick();
    chk("restart_no_repulse", 12'(restart_req), 12'h0);
    step(3);
    chk("restart_overlay", vid.rgb_out, 12'h3C1);
    chk("restart_freeze", 12'(freeze), 12'h1);
    game_over = 1'b0;
    step(2);
    chk("restart_hold", 12'(freeze), 12'h1);
    tick();
    chk("back_play", 12'(freeze), 12'h0);
    step(3);
    chk("back_play_rgb", vid.rgb_out, 12'hF84);
    game_over = 1'b1;
    tick();
    repeat (90) tick();
    chk("show2_freeze", 12'(freeze), 12'h1);
    frame_tick = 1'b1; restart_btn = 1'b1;
    step(1);
    frame_tick = 1'b0; restart_btn = 1'b0;
    chk("coincide_req", 12'(restart_req), 12'h1);
    step(1);
    chk("coincide_single", 12'(restart_req), 12'h0);
    game_over = 1'b0;
    tick();
    chk("play2", 12'(freeze), 12'h0);
    game_over = 1'b1;
    tick();
    chk("flash3", 12'(freeze), 12'h1);
    step(3);
    chk("pre_rst_row", 12'(vid.rom_row), 12'h7);
    #2 reset = 1'b1;
    #1;
    chk("arst_rgb", vid.rgb_out, 12'h000);
    chk("arst_freeze", 12'(freeze), 12'h0);
    chk("arst_row", 12'(vid.rom_row), 12'h0);
    chk("arst_col", 12'(vid.rom_col), 12'h0);
    chk("arst_req", 12'(restart_req), 12'h0);
    @(posedge clk);
    #1;
    reset = 1'b0; game_over = 1'b0; vid.game_rgb = 12'h5A5;
    step(3);
    chk("post_rst_rgb", vid.rgb_out, 12'h5A5);
    tick();
    chk("post_rst_play", 12'(freeze), 12'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_over_ctrl.md
Name: game_over_ctrl

Overview:
Sequences the 32x64 game-over sprite ROM (12-bit RGB, one registered-address cycle of read latency) onto the 640x480 VGA stream when the snake game ends. Maps pixel coordinates to ROM row/col and aligns the ROM output with the game's own pixel colour. Runs the end-of-game flow: freeze, flashing banner, steady banner, restart handshake. Sits between the game renderer/ROM and the VGA colour output register.

Parameters:
SHIFT, 3, log2 of sprite scale; each ROM cell is drawn as 8x8 pixels.
X_OFFSET, 64, left edge of sprite window in pixels.
Y_OFFSET, 112, top edge of sprite window in pixels.
FLASH_FRAMES, 15, frames per flash half-period.
FLASH_TOGGLES, 6, visibility toggles in FLASH; must be even.

Ports:
clk  input  1  pixel-domain clock
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse at start of vertical blank
game_over  input  1  level from game logic; high = snake dead
restart_btn  input  1  debounced one-cycle restart pulse
video_on  input  1  active-video flag for current pixel
pixel_x  input  10  current pixel column
pixel_y  input  10  current pixel row
game_rgb  input  12  game renderer colour for current pixel
rom_color  input  12  sprite ROM colour_data
rom_row  output  5  sprite ROM row address
rom_col  output  6  sprite ROM column address
rgb_out  output  12  final pixel colour
freeze  output  1  high = game logic must stop stepping
restart_req  output  1  one-cycle pulse requesting game reset

Behaviour:
- Clocking: single clk; reset is asynchronous and active-high.
- Reset: state=PLAY; frame_cnt, toggle_cnt, vis, restart_pending and all pipeline registers cleared. rom_row=0, rom_col=0, rgb_out=0, freeze=0, restart_req=0.
- Address stage (cycle 1): in_win = (X_OFFSET <= pixel_x < X_OFFSET+(64<<SHIFT)) and (Y_OFFSET <= pixel_y < Y_OFFSET+(32<<SHIFT)). rom_row/rom_col registered as (pixel_y-Y_OFFSET)>>SHIFT and (pixel_x-X_OFFSET)>>SHIFT, truncated to 5/6 bits. Outside the window both are 0.
- ROM returns rom_color at cycle 2. in_win, video_on and game_rgb are delayed 2 cycles to match.
- Output stage (cycle 3, registered): pixel-to-rgb_out latency is exactly 3 clk.
  - video_on_d=0 -> 12'h000.
  - Overlay off -> game_rgb_d.
  - Overlay on, in_win_d and rom_color!=0 -> rom_color.
  - Otherwise -> dim(game_rgb_d), where each 4-bit channel is shifted right by 1 (F84 -> 742).
  - Overlay on = state!=PLAY and vis=1. During FLASH with vis=0, the whole frame is dimmed.
- FSM: state changes only on frame_tick, so the display never tears mid-frame.
  - PLAY: freeze=0. On frame_tick with game_over=1 -> FLASH; vis=1, frame_cnt=0, toggle_cnt=0.
  - FLASH: freeze=1. Each frame_tick increments frame_cnt. When frame_cnt==FLASH_FRAMES-1 on a tick: frame_cnt=0, vis toggles, toggle_cnt++. When toggle_cnt reaches FLASH_TOGGLES -> SHOW with vis=1. restart_btn is ignored and does not latch.
  - SHOW: freeze=1, vis=1. restart_btn sets restart_pending on any cycle. On frame_tick with restart_pending=1 -> RESTART; restart_pending cleared, restart_req=1 for exactly that one cycle.
  - RESTART: freeze=1, overlay still shown. On frame_tick with game_over=0 -> PLAY; vis=0, freeze=0 from the next cycle. While game_over stays 1, the block remains in RESTART and does not re-pulse.
- frame_tick coinciding with restart_btn in SHOW: the pulse is latched and acted on at the same tick.
- Reset asserted mid-operation: immediate return to reset values regardless of state; no restart_req emitted.

Test Plan:
1. Assert reset while in FLASH -> rgb_out=000, freeze=0, rom_row/col=0 asynchronously. After release with game_over=0, the block stays in PLAY and rgb_out tracks game_rgb 3 cycles later.
2. game_over rises mid-frame -> freeze stays 0 until the cycle after the next frame_tick, then 1. Banner pixels equal rom_color; other pixels show game_rgb F84 as 742.
3. Flash timing with defaults -> visible for ticks 1-15, dimmed for 16-30, and so on; SHOW entered after 90 frame_ticks with vis=1.
4. Address/latency with a stub ROM -> pixel (64,112) gives row 0, col 0. Pixel (327,175) gives row 7, col 32, and rgb_out equals rom_color exactly 3 cycles after the pixel. Pixel (576,112) is outside the window: address 0, dimmed output.
5. restart_btn during FLASH -> no restart_req. restart_btn in SHOW -> a single one-cycle restart_req at the next frame_tick. Drop game_over -> PLAY at the following tick, freeze=0.
6. video_on=0 with overlay active -> rgb_out=000 three cycles later.
